// File: rtl/stage_seq_if.sv
// Bundle of the sequencer's control, coefficient-memory, configuration and data streams.
// master = stage_seq side, slave = environment side.
interface stage_seq_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [3:0]        load_depth;
  logic [2:0]        bias_length;
  logic [7:0]        data_words;
  logic              busy;
  logic              done;

  logic              mem_rd_en;
  logic [4:0]        mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;

  logic [DATA_W-1:0] cfg_data;
  logic              cfg_vld;
  logic              cfg_fst;
  logic              cfg_bias;
  logic              cfg_rdy;

  logic              data_in_vld;
  logic              data_in_fst;
  logic [DATA_W-1:0] data_in;
  logic              data_in_rdy;

  logic              stage_data_vld;
  logic              stage_data_fst;
  logic [DATA_W-1:0] stage_data;
  logic              stage_data_rdy;

  modport master (
    input  start, load_depth, bias_length, data_words, mem_rd_data, cfg_rdy,
           data_in_vld, data_in_fst, data_in, stage_data_rdy,
    output busy, done, mem_rd_en, mem_rd_addr, cfg_data, cfg_vld, cfg_fst, cfg_bias,
           data_in_rdy, stage_data_vld, stage_data_fst, stage_data
  );

  modport slave (
    output start, load_depth, bias_length, data_words, mem_rd_data, cfg_rdy,
           data_in_vld, data_in_fst, data_in, stage_data_rdy,
    input  busy, done, mem_rd_en, mem_rd_addr, cfg_data, cfg_vld, cfg_fst, cfg_bias,
           data_in_rdy, stage_data_vld, stage_data_fst, stage_data
  );
endinterface

// File: rtl/stage_seq.sv
// Loads tap and bias words from coefficient memory into a stage through a 2-entry
// return buffer, drains it, then gates a bounded number of data words into the stage.
module stage_seq #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  stage_seq_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic              fst;
    logic              bias;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e r_state;
  state_e w_next;

  logic [3:0] r_load_depth;
  logic [2:0] r_bias_len;
  logic [7:0] r_data_words;
  logic [4:0] r_addr;
  logic       r_inflight;
  logic       r_if_fst;
  logic       r_if_bias;
  entry_t     r_fifo [FIFO_DEPTH];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic [7:0] r_run_cnt;

  logic       w_start;
  logic       w_cfg_vld;
  logic       w_pop;
  logic [2:0] w_occ;
  logic       w_rd_en;
  logic [4:0] w_last_addr;
  logic       w_hs;
  entry_t     w_head;

  assign w_start     = (r_state == S_IDLE) && bus.start;
  assign w_cfg_vld   = (r_count != 2'd0);
  assign w_pop       = w_cfg_vld && bus.cfg_rdy;
  // Occupancy counts the in-flight read so a returning word always has a slot.
  assign w_occ       = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
  assign w_rd_en     = (r_state == S_LOAD) && (w_occ < 3'(FIFO_DEPTH));
  assign w_last_addr = 5'(r_load_depth) + 5'(r_bias_len) + 5'd1;
  assign w_hs        = (r_state == S_RUN) && bus.data_in_vld && bus.stage_data_rdy;
  assign w_head      = r_fifo[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_LOAD;
      S_LOAD:  if (w_rd_en && (r_addr == w_last_addr)) w_next = S_FLUSH;
      S_FLUSH: if ((r_count == 2'd0) && !r_inflight) w_next = S_RUN;
      S_RUN:   if (w_hs && (r_run_cnt == r_data_words)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy           = (r_state != S_IDLE);
    bus.done           = (r_state == S_DONE);
    bus.mem_rd_en      = w_rd_en;
    bus.mem_rd_addr    = r_addr;
    bus.cfg_vld        = w_cfg_vld;
    bus.cfg_data       = '0;
    bus.cfg_fst        = 1'b0;
    bus.cfg_bias       = 1'b0;
    bus.data_in_rdy    = 1'b0;
    bus.stage_data_vld = 1'b0;
    bus.stage_data_fst = 1'b0;
    bus.stage_data     = '0;
    if (w_cfg_vld) begin
      bus.cfg_data = w_head.data;
      bus.cfg_fst  = w_head.fst;
      bus.cfg_bias = w_head.bias;
    end
    if (r_state == S_RUN) begin
      bus.data_in_rdy    = bus.stage_data_rdy;
      bus.stage_data_vld = bus.data_in_vld;
      bus.stage_data_fst = bus.data_in_fst;
      bus.stage_data     = bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load_depth <= '0;
      r_bias_len   <= '0;
      r_data_words <= '0;
      r_addr       <= '0;
      r_inflight   <= 1'b0;
      r_if_fst     <= 1'b0;
      r_if_bias    <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_count      <= '0;
      r_run_cnt    <= '0;
    end else begin
      if (w_start) begin
        r_load_depth <= bus.load_depth;
        r_bias_len   <= bus.bias_length;
        r_data_words <= bus.data_words;
        r_addr       <= '0;
        r_run_cnt    <= '0;
      end
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_addr    <= r_addr + 5'd1;
        r_if_fst  <= (r_addr == 5'd0) || (r_addr == 5'(r_load_depth) + 5'd1);
        r_if_bias <= (r_addr > 5'(r_load_depth));
      end
      if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
      if (w_hs) r_run_cnt <= r_run_cnt + 8'd1;
    end
  end

  // NOTE: buffer storage is not reset; its outputs are masked by cfg_vld while empty.
  always_ff @(posedge clk) begin
    if (r_inflight) r_fifo[r_wr_ptr] <= '{fst: r_if_fst, bias: r_if_bias, data: bus.mem_rd_data};
  end

endmodule

// File: tb/tb_stage_seq.sv
// Self-checking bench for stage_seq: scoreboard of expected read addresses and
// configuration words, plus per-cycle checks of timing, gating and handshakes.
module tb_stage_seq;
  localparam int DATA_W = 32;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              fst;
    logic              bias;
    logic [4:0]        addr;
  } cfg_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [DATA_W-1:0] mem_model [32];

  stage_seq_if #(.DATA_W(DATA_W)) bus ();

  stage_seq #(.DATA_W(DATA_W), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Coefficient memory: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem_model[bus.mem_rd_addr];
  end

  function automatic logic [DATA_W+10:0] all_outs();
    return {bus.busy, bus.done, bus.mem_rd_en, bus.mem_rd_addr, bus.cfg_vld, bus.cfg_fst,
            bus.cfg_bias, bus.data_in_rdy, bus.stage_data_vld, bus.stage_data_fst} == '0
           ? {bus.cfg_data | bus.stage_data, 11'd0} : '1;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b1; bus.cfg_rdy = 1'b1; bus.data_in_vld = 1'b1; bus.data_in_fst = 1'b1;
    bus.data_in = 32'hDEAD_BEEF; bus.stage_data_rdy = 1'b1;
    bus.load_depth = 4'd3; bus.bias_length = 3'd1; bus.data_words = 8'd4;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, want all-zero", all_outs());
    end
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: got %b, want 0", bus.busy);
    end
  endtask

  // Runs one full sequence with a scoreboard of expected reads and config words.
  task automatic run_seq(input logic [3:0] ld, input logic [2:0] bl, input logic [7:0] dw,
                         input bit timing, input bit bp, input bit poke);
    cfg_exp_t e;
    cfg_exp_t q_cfg [$];
    logic [4:0] q_addr [$];
    int n, cycle, last_pop, done_cyc, hs, occ, new_occ;
    bit all_popped, prev_stall, in_run, pop, fin;
    logic [DATA_W-1:0] pd;
    logic pf, pb;
    n = int'(ld) + int'(bl) + 2;
    cycle = 0; last_pop = -100; done_cyc = -1; hs = 0; occ = 0;
    all_popped = 0; prev_stall = 0; fin = 0;
    pd = '0; pf = 1'b0; pb = 1'b0;
    for (int a = 0; a < n; a++) begin
      e.addr = 5'(a);
      e.data = mem_model[a];
      e.fst  = (a == 0) || (a == int'(ld) + 1);
      e.bias = (a > int'(ld));
      q_cfg.push_back(e);
      q_addr.push_back(5'(a));
    end
    @(negedge clk);
    bus.start = 1'b1; bus.load_depth = ld; bus.bias_length = bl; bus.data_words = dw;
    bus.cfg_rdy = 1'b1; bus.data_in_vld = 1'b1; bus.stage_data_rdy = 1'b1;
    bus.data_in = $urandom; bus.data_in_fst = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL busy_c0: got %b, want 0", bus.busy);
    end
    while (!fin) begin
      @(negedge clk);
      cycle++;
      bus.start = poke && (cycle == 2 || (all_popped && cycle == last_pop + 2) || cycle == done_cyc);
      bus.load_depth  = 4'($urandom);
      bus.bias_length = 3'($urandom);
      bus.data_words  = 8'($urandom);
      bus.cfg_rdy        = bp ? ((cycle - 1) % 3 == 0) : 1'b1;
      bus.stage_data_rdy = bp ? (cycle % 2 == 1) : 1'b1;
      bus.data_in_vld    = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.data_in        = $urandom;
      bus.data_in_fst    = (hs == 0);
      #1;
      in_run = all_popped && cycle >= last_pop + 2 && (done_cyc < 0 || cycle < done_cyc);

      n_checks++;
      if (bus.busy !== (done_cyc < 0 || cycle <= done_cyc)) begin
        n_fail++; $display("FAIL busy c%0d: got %b", cycle, bus.busy);
      end
      n_checks++;
      if (bus.done !== (cycle == done_cyc)) begin
        n_fail++; $display("FAIL done c%0d: got %b, want %b", cycle, bus.done, cycle == done_cyc);
      end
      if (timing) begin
        n_checks++;
        if (bus.mem_rd_en !== (cycle >= 1 && cycle <= n)) begin
          n_fail++; $display("FAIL rd_en_timing c%0d: got %b", cycle, bus.mem_rd_en);
        end
        n_checks++;
        if (bus.cfg_vld !== (cycle >= 3 && cycle <= n + 2)) begin
          n_fail++; $display("FAIL cfg_vld_timing c%0d: got %b", cycle, bus.cfg_vld);
        end
      end

      pop = bus.cfg_vld && bus.cfg_rdy;
      if (prev_stall) begin
        n_checks++;
        if (bus.cfg_vld !== 1'b1 || bus.cfg_data !== pd || bus.cfg_fst !== pf || bus.cfg_bias !== pb) begin
          n_fail++;
          $display("FAIL cfg_hold c%0d: got vld=%b d=%h f=%b b=%b, want d=%h f=%b b=%b",
                   cycle, bus.cfg_vld, bus.cfg_data, bus.cfg_fst, bus.cfg_bias, pd, pf, pb);
        end
      end
      if (bus.mem_rd_en) begin
        n_checks++;
        if (q_addr.size() == 0) begin
          n_fail++; $display("FAIL rd_addr c%0d: extra read at %0d", cycle, bus.mem_rd_addr);
        end else begin
          if (bus.mem_rd_addr !== q_addr[0]) begin
            n_fail++; $display("FAIL rd_addr c%0d: got %0d, want %0d", cycle, bus.mem_rd_addr, q_addr[0]);
          end
          void'(q_addr.pop_front());
        end
      end
      new_occ = occ + int'(bus.mem_rd_en) - int'(pop);
      if (bus.mem_rd_en) begin
        n_checks++;
        if (new_occ > 2) begin
          n_fail++; $display("FAIL occupancy c%0d: got %0d, want <= 2", cycle, new_occ);
        end
      end
      occ = new_occ;
      if (pop) begin
        n_checks++;
        if (q_cfg.size() == 0) begin
          n_fail++; $display("FAIL cfg_word c%0d: unexpected word %h", cycle, bus.cfg_data);
        end else begin
          e = q_cfg.pop_front();
          if (bus.cfg_data !== e.data || bus.cfg_fst !== e.fst || bus.cfg_bias !== e.bias) begin
            n_fail++;
            $display("FAIL cfg_word addr%0d c%0d: got d=%h f=%b b=%b, want d=%h f=%b b=%b",
                     e.addr, cycle, bus.cfg_data, bus.cfg_fst, bus.cfg_bias, e.data, e.fst, e.bias);
          end
          if (q_cfg.size() == 0) begin
            all_popped = 1; last_pop = cycle;
          end
        end
      end
      prev_stall = bus.cfg_vld && !bus.cfg_rdy;
      pd = bus.cfg_data; pf = bus.cfg_fst; pb = bus.cfg_bias;

      n_checks++;
      if (in_run) begin
        if (bus.stage_data_vld !== bus.data_in_vld || bus.data_in_rdy !== bus.stage_data_rdy ||
            bus.stage_data !== bus.data_in || bus.stage_data_fst !== bus.data_in_fst) begin
          n_fail++;
          $display("FAIL run_pass c%0d: got vld=%b rdy=%b d=%h f=%b", cycle,
                   bus.stage_data_vld, bus.data_in_rdy, bus.stage_data, bus.stage_data_fst);
        end
        if (bus.data_in_vld && bus.stage_data_rdy) begin
          hs++;
          if (hs == int'(dw) + 1) done_cyc = cycle + 1;
        end
      end else if (bus.stage_data_vld !== 1'b0 || bus.data_in_rdy !== 1'b0 || bus.stage_data !== '0) begin
        n_fail++;
        $display("FAIL run_gate c%0d: got vld=%b rdy=%b d=%h, want 0", cycle,
                 bus.stage_data_vld, bus.data_in_rdy, bus.stage_data);
      end

      if (done_cyc >= 0 && cycle == done_cyc + 1) fin = 1;
      if (cycle > 3000) begin
        n_checks++; n_fail++;
        $display("FAIL timeout: sequence not finished after %0d cycles", cycle);
        fin = 1;
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (q_cfg.size() != 0 || q_addr.size() != 0) begin
      n_fail++; $display("FAIL leftovers: got %0d words, %0d reads missing, want 0", q_cfg.size(), q_addr.size());
    end
    n_checks++;
    if (hs != int'(dw) + 1) begin
      n_fail++; $display("FAIL hs_count: got %0d, want %0d", hs, int'(dw) + 1);
    end
    if (timing) begin
      n_checks++;
      if (last_pop != n + 2) begin
        n_fail++; $display("FAIL run_start: got %0d, want %0d", last_pop + 2, n + 4);
      end
    end
  endtask

  task automatic test_basic_load();      run_seq(4'd3, 3'd1, 8'd4, 1'b1, 1'b0, 1'b0); endtask
  task automatic test_backpressure();    run_seq(4'd3, 3'd1, 8'd4, 1'b0, 1'b1, 1'b0); endtask
  task automatic test_minimal();         run_seq(4'd0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0); endtask
  task automatic test_max_lengths();     run_seq(4'd15, 3'd7, 8'd3, 1'b1, 1'b0, 1'b0); endtask
  task automatic test_start_while_busy(); run_seq(4'd2, 3'd2, 8'd6, 1'b1, 1'b0, 1'b1); endtask
  task automatic test_run_gating();      run_seq(4'd1, 3'd2, 8'd9, 1'b0, 1'b1, 1'b0); endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start = 1'b1; bus.load_depth = 4'd3; bus.bias_length = 3'd1; bus.data_words = 8'd4;
    bus.cfg_rdy = 1'b0; bus.data_in_vld = 1'b1; bus.stage_data_rdy = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_rd_en !== (c <= 2) || (c <= 2 && bus.mem_rd_addr !== 5'(c - 1)) || bus.cfg_vld !== (c == 3)) begin
        n_fail++;
        $display("FAIL mid_load c%0d: got rd=%b addr=%0d vld=%b", c, bus.mem_rd_en, bus.mem_rd_addr, bus.cfg_vld);
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h, want all-zero", all_outs());
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.cfg_vld !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got busy=%b vld=%b, want 0", bus.busy, bus.cfg_vld);
    end
    run_seq(4'd3, 3'd1, 8'd4, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_model[i] = $urandom;
    test_reset();
    test_basic_load();
    test_backpressure();
    test_minimal();
    test_max_lengths();
    test_start_while_busy();
    test_reset_mid();
    test_run_gating();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
